// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_trial_sub.sv
// Trial subtraction a - b by complement-and-add with carry-in 1.
// a carries one extra bit (the shifted-out remainder MSB); the difference is
// only consumed when there is no borrow, where it always fits in W bits.
module div_trial_sub #(
    parameter int unsigned W = 8
) (
    input  logic [W:0]   a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W+1:0] sum_c;
    logic         unused_c;

    // Carry-out of a + ~b + 1 is the inverted borrow.
    assign sum_c    = {1'b0, a_i} + {1'b0, ~{1'b0, b_i}} + (W + 2)'(1);
    assign borrow_o = ~sum_c[W+1];
    assign diff_o   = sum_c[W-1:0];
    assign unused_c = sum_c[W];

endmodule : div_trial_sub

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/done handshake, held result registers and divide-by-zero flag.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_e       state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH-1:0] diff_c;
    logic             borrow_c;
    logic [WIDTH-1:0] quo_nxt_c;
    logic [WIDTH-1:0] rem_nxt_c;

    // Shift {rem,quo} left by one; the remainder keeps its carried-out MSB.
    assign rem_sh_c  = {rem_q, quo_q[WIDTH-1]};
    assign quo_nxt_c = {quo_q[WIDTH-2:0], ~borrow_c};
    assign rem_nxt_c = borrow_c ? rem_sh_c[WIDTH-1:0] : diff_c;

    div_trial_sub #(
        .W(WIDTH)
    ) u_trial_sub (
        .a_i      (rem_sh_c),
        .b_i      (dvs_q),
        .diff_o   (diff_c),
        .borrow_o (borrow_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && (divisor != '0)) begin
                        dvs_q     <= divisor;
                        rem_q     <= '0;
                        quo_q     <= dividend;
                        cnt_q     <= CW'(WIDTH);
                        busy      <= 1'b1;
                        divByZero <= 1'b0;
                        state_q   <= S_RUN;
                    end else if (start) begin
                        // Divide by zero completes immediately with saturated quotient.
                        quotient  <= '1;
                        remainder <= dividend;
                        divByZero <= 1'b1;
                        done      <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    quo_q <= quo_nxt_c;
                    rem_q <= rem_nxt_c;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quotient  <= quo_nxt_c;
                        remainder <= rem_nxt_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         divByZero;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cyc_cnt  = 0;
    int t_acc    = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: results come from / and %, timing from a remaining-cycles count.
    logic         m_busy, m_done, m_z;
    logic [W-1:0] m_q, m_r, p_q, p_r, p_a, p_b;
    int           m_left;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_z <= 1'b0;
            m_q <= '0; m_r <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0 && start) begin
                if (divisor == '0) begin
                    m_q <= '1; m_r <= dividend; m_z <= 1'b1; m_done <= 1'b1;
                end else begin
                    p_q <= dividend / divisor; p_r <= dividend % divisor;
                    p_a <= dividend; p_b <= divisor;
                    m_left <= W; m_busy <= 1'b1; m_z <= 1'b0;
                end
            end else if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_q <= p_q; m_r <= p_r;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("divByZero", divByZero, m_z);
            chk("busy_done_exclusive", busy & done, 0);
            if (done && !divByZero) begin
                chk("invariant", 32'(quotient) * 32'(p_b) + 32'(remainder), 32'(p_a));
                chk("rem_lt_divisor", remainder < p_b, 1);
            end
        end
    end

    // Call at a negedge: presents one start pulse, returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        t_acc = cyc_cnt;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done, 1);
        lat = cyc_cnt - t_acc;
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input int elat);
        int lat;
        start_op(a, b);
        wait_done(lat);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_quotient"}, quotient, eq);
        chk({name, "_remainder"}, remainder, er);
        chk({name, "_divByZero"}, divByZero, ez);
    endtask

    initial begin
        int lat;
        int n_done;
        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_quotient", quotient, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);

        run_lit("t1_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
        @(negedge clk);
        run_lit("t2_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        run_lit("t2_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
        @(negedge clk);
        run_lit("t3_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
        run_lit("t3_0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8);
        run_lit("t3_200_129", 8'd200, 8'd129, 8'd1, 8'd71, 1'b0, 8);
        run_lit("t3_254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 8);
        @(negedge clk);
        run_lit("t4_77_0", 8'd77, 8'd0, 8'd255, 8'd77, 1'b1, 0);
        @(negedge clk);

        // Start ignored while busy.
        start_op(8'd200, 8'd13);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("t5_latency", lat, 8);
        chk("t5_quotient", quotient, 15);
        chk("t5_remainder", remainder, 5);
        @(negedge clk);

        // Reset in cycle 4 of RUN aborts without a done pulse.
        start_op(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_quotient", quotient, 0);
        chk("t6_remainder", remainder, 0);
        chk("t6_busy", busy, 0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("t6_no_done", n_done, 0);

        // Back-to-back start in the DONE cycle.
        run_lit("t7_first", 8'd60, 8'd7, 8'd8, 8'd4, 1'b0, 8);
        run_lit("t7_second", 8'd250, 8'd16, 8'd15, 8'd10, 1'b0, 8);
        run_lit("t7_div0_back", 8'd9, 8'd0, 8'd255, 8'd9, 1'b1, 0);
        run_lit("t7_after_div0", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 8);
        @(negedge clk);

        // Random operand sweep; the model and invariant are checked every cycle.
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(0, 255));
            case (i % 4)
                0: b = W'($urandom_range(129, 255));
                1: b = W'($urandom_range(1, 15));
                default: b = W'($urandom_range(0, 255));
            endcase
            if (i % 37 == 0) b = '0;
            start_op(a, b);
            wait_done(lat);
            if (($urandom & 1) == 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_divider
